// File: rtl/candidate_membank_pkg.sv
// ---------------------------------------------------------------------------
// candidate_membank_pkg
// Shared definitions for the byte-addressed word memory bank: the state type
// of the clear sequencer and the default geometry constants used as
// parameter defaults by candidate_membank.
// ---------------------------------------------------------------------------
package candidate_membank_pkg;

    // IDLE accepts word requests; CLEAR walks the array zeroing one word per cycle
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } membankState_t;

    localparam int DEF_BYTE_W = 8;
    localparam int DEF_WORD_W = 16;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/candidate_membank_clr_seq.sv
// ---------------------------------------------------------------------------
// candidate_membank_clr_seq
// Clear sequencer for candidate_membank: owns the IDLE/CLEAR state machine
// and the word pointer that sweeps the array from word 0 upwards.
//
// Ports:
//   i_clk      sole clock, rising edge
//   i_rst      synchronous active-high reset (forces CLEAR, pointer 0)
//   i_clr      start (or restart) a full-memory clear
//   o_busy     high while the clear sequence runs (and while in reset)
//   o_clrWe    write strobe for the zeroing port of the byte array
//   o_clrWord  index of the word being zeroed this cycle
// ---------------------------------------------------------------------------
module candidate_membank_clr_seq
    import candidate_membank_pkg::*;
#(
    parameter int NWORDS = 16,
    parameter int PTR_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    output logic             o_busy,
    output logic             o_clrWe,
    output logic [PTR_W-1:0] o_clrWord
);

    membankState_t    r_state;
    membankState_t    w_stateNext;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptrNext;

    // State and pointer registers. Reset lands in CLEAR so that the array is
    // always swept to zero before the first request can be accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
        end
    end

    // Next-state logic. Each CLEAR cycle zeroes the word under the pointer;
    // a fresh clr during CLEAR rewinds the pointer so a full sweep follows.
    // The last word leaves CLEAR on the same edge that zeroes it.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        o_clrWe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_stateNext = ST_CLEAR;
                    w_ptrNext   = '0;
                end
            end
            ST_CLEAR: begin
                o_clrWe = ~i_rst;
                if (i_clr) begin
                    w_ptrNext = '0;
                end else if (r_ptr == PTR_W'(NWORDS - 1)) begin
                    w_stateNext = ST_IDLE;
                    w_ptrNext   = '0;
                end else begin
                    w_ptrNext = r_ptr + PTR_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_CLEAR;
                w_ptrNext   = '0;
            end
        endcase
    end

    // busy is forced high during reset so requests are refused immediately,
    // even before the first reset edge has moved the state register.
    assign o_busy    = (r_state == ST_CLEAR) | i_rst;
    assign o_clrWord = r_ptr;

endmodule

// File: rtl/candidate_membank.sv
// ---------------------------------------------------------------------------
// candidate_membank
// Byte-addressed memory bank with big-endian word access. A word at index i
// occupies bytes i, i+1, ... (mod DEPTH), most significant byte first.
// Reads are registered (one cycle latency, read-first against a same-cycle
// write); out-of-range or busy-time requests are rejected with an err pulse.
// A clear sequence zeroes the whole array after reset or on clr.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   wr_en     word write request
//   rd_en     word read request
//   clr       start a full-memory clear
//   index     byte address of the word's most significant byte
//   data_in   write data
//   data_out  registered read data
//   rd_valid  one-cycle pulse, data_out holds a new read result
//   busy      clear sequence in progress
//   err       one-cycle pulse, request rejected
// ---------------------------------------------------------------------------
module candidate_membank
    import candidate_membank_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] index,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int BPW = WORD_W / BYTE_W;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW  = DEPTH / BPW;
    localparam int PW  = (NW > 1) ? $clog2(NW) : 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_dout;
    logic              r_rdValid;
    logic              r_err;

    logic              w_busy;
    logic              w_clrWe;
    logic [PW-1:0]     w_clrWord;
    logic [AW-1:0]     w_clrBase;
    logic [AW-1:0]     w_base;
    logic [AW-1:0]     w_addr [BPW];
    logic [WORD_W-1:0] w_rdWord;
    logic              w_inRange;
    logic              w_accept;
    logic              w_reject;

    candidate_membank_clr_seq #(
        .NWORDS (NW),
        .PTR_W  (PW)
    ) u_clrSeq (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (clr),
        .o_busy    (w_busy),
        .o_clrWe   (w_clrWe),
        .o_clrWord (w_clrWord)
    );

    // Range check is done on the full index width with one spare bit so that
    // DEPTH equal to 2**ADDR_W still compares correctly.
    assign w_inRange = ({1'b0, index} < (ADDR_W + 1)'(DEPTH));
    assign w_base    = index[AW-1:0];
    assign w_clrBase = AW'(w_clrWord) * AW'(BPW);

    // A request is taken only in IDLE with a legal index; clr in IDLE wins
    // silently over wr/rd. Anything arriving while busy, or out of range
    // without a competing clr, is refused with err.
    assign w_accept = ~w_busy & ~clr & w_inRange;
    assign w_reject = (wr_en | rd_en) & (w_busy | (~clr & ~w_inRange));

    // Byte addresses of the word. Truncating the sum to AW bits gives the
    // wrap from DEPTH-1 back to 0 for free, since DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < BPW; k++) begin
            w_addr[k] = w_base + AW'(k);
        end
    end

    // Gather the addressed bytes into a word, byte 0 in the top lane.
    always_comb begin
        w_rdWord = '0;
        for (int k = 0; k < BPW; k++) begin
            w_rdWord[WORD_W-1-k*BYTE_W -: BYTE_W] = r_mem[w_addr[k]];
        end
    end

    // Byte array writes. The clear port and the request port never collide
    // because requests are only accepted when the sequencer is idle. The
    // array itself is not reset; the automatic clear after reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clrWe) begin
                for (int k = 0; k < BPW; k++) begin
                    r_mem[w_clrBase + AW'(k)] <= '0;
                end
            end else if (w_accept && wr_en) begin
                for (int k = 0; k < BPW; k++) begin
                    r_mem[w_addr[k]] <= data_in[WORD_W-1-k*BYTE_W -: BYTE_W];
                end
            end
        end
    end

    // Read register and status pulses. The read samples the array before
    // this edge's write lands, which gives read-first behaviour. data_out
    // only moves on an accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout    <= '0;
            r_rdValid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rdValid <= w_accept & rd_en;
            r_err     <= w_reject;
            if (w_accept && rd_en) begin
                r_dout <= w_rdWord;
            end
        end
    end

    assign data_out = r_dout;
    assign rd_valid = r_rdValid;
    assign err      = r_err;
    assign busy     = w_busy;

endmodule

// File: doc/candidate_membank.md
CANDIDATE_MEMBANK -- requirements
Module: candidate_membank

Interface
REQ-001 Parameter BYTE_W, default 8, SHALL set the width of one storage byte in bits.
REQ-002 Parameter WORD_W, default 16, SHALL set the word width; it SHALL be an integer multiple of BYTE_W, giving BPW = WORD_W/BYTE_W bytes per word.
REQ-003 Parameter DEPTH, default 32, SHALL set storage size in bytes; it SHALL be a power of two and a multiple of BPW.
REQ-004 Parameter ADDR_W, default 16, SHALL set the index port width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  word write request.
REQ-009 rd_en  in  1  word read request.
REQ-010 clr  in  1  start a full-memory clear.
REQ-011 index  in  ADDR_W  byte address of the word's most significant byte.
REQ-012 data_in  in  WORD_W  write data.
REQ-013 data_out  out  WORD_W  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse: data_out holds a new read result.
REQ-015 busy  out  1  clear sequence in progress.
REQ-016 err  out  1  one-cycle pulse: request rejected.

Function
REQ-017 Storage SHALL be big-endian: byte k of a word (k=0 is the MSB byte) SHALL live at address (index+k) mod DEPTH.
REQ-018 Byte addresses within one word SHALL wrap from DEPTH-1 to 0.
REQ-019 A request with index >= DEPTH SHALL be rejected: no memory change, no rd_valid, err=1 on the next cycle.
REQ-020 Write: with wr_en=1 in IDLE and a valid index, all BPW bytes SHALL update at that clock edge.
REQ-021 Read latency: with rd_en=1 in IDLE and a valid index, data_out SHALL update and rd_valid SHALL be 1 on the following cycle. data_out SHALL hold its value otherwise.
REQ-022 With wr_en and rd_en both set to overlapping bytes, the read SHALL return pre-write data (read-first). The write SHALL still occur.
REQ-023 FSM states: IDLE and CLEAR.
REQ-024 IDLE->CLEAR on clr=1. CLEAR->IDLE after the cycle that zeroes the final word. busy=1 exactly while in CLEAR.
REQ-025 CLEAR SHALL zero BPW bytes per cycle, starting at address 0 in ascending order, and SHALL take DEPTH/BPW cycles.
REQ-026 clr in IDLE together with wr_en or rd_en: clr wins, the other requests are dropped, err stays 0.
REQ-027 clr while in CLEAR SHALL restart the clear pointer at 0.
REQ-028 wr_en or rd_en while busy SHALL be ignored and SHALL set err=1 on the next cycle.
REQ-029 rd_valid and err SHALL never remain high for two consecutive cycles for the same request.

Reset
REQ-030 While rst=1: data_out=0, rd_valid=0, err=0, busy=1, clear pointer=0, state=CLEAR.
REQ-031 After rst deasserts, the block SHALL complete an automatic clear (DEPTH/BPW cycles) before accepting requests.
REQ-032 rst asserted mid-clear or mid-request SHALL abandon the operation and apply REQ-030 on that edge.

Structure
REQ-033 Package candidate_membank_pkg SHALL hold the FSM state type and the default BYTE_W, WORD_W, DEPTH and ADDR_W constants.
REQ-034 The byte array, address wrap logic and read register SHALL stay in candidate_membank.
REQ-035 One sub-module, candidate_membank_clr_seq (clear pointer plus FSM), SHALL drive busy and the clear write port.

Verification (default parameters, clear = 16 cycles)
REQ-036 Release rst -> busy=1 for 16 cycles then 0; then rd index 5 -> next cycle data_out=0x0000, rd_valid=1.
REQ-037 wr index 4 data 0xABCD; then rd 4 -> 0xABCD; then rd 5 -> 0xCD00.
REQ-038 wr index 31 data 0x1234 -> byte31=0x12, byte0=0x34; rd 0 -> 0x3400; rd 31 -> 0x1234.
REQ-039 wr index 32 data 0xFFFF -> err=1 next cycle, no change; rd 0 unchanged.
REQ-040 After REQ-037, wr 4 data 0x5555 with rd 4 in the same cycle -> data_out=0xABCD; next rd 4 -> 0x5555.
REQ-041 clr; wr 2 at clear cycle 3 -> err=1, write dropped. clr again at cycle 8 -> busy lasts 16 more cycles; afterwards every word reads 0x0000.
